// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 action decoder: scancodes,
// decode-FSM states and action bit indices.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  localparam int ACT_RIGHT = 0;
  localparam int ACT_LEFT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit framing,
// stop/timeout checking; parity checking when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [TW-1:0]          tcnt;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic                   parity_ok;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  assign parity_ok = odd_parity_ok(shreg, parity_bit);
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: synchronisers reset to 1 (the idle level of both PS/2 lines) so that
  // releasing reset can never manufacture a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments everywhere here; every flop samples
      // the pre-edge values, which is what makes the sync chain a chain.
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;

      if (fall) begin
        tcnt <= '0;
        case (bit_cnt)
          4'd0: if (!data_s) bit_cnt <= 4'd1;
          4'd9: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= data_s;
`endif
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= '0;
            if (data_s && parity_ok) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
          end
          default: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end else if (bit_cnt != 4'd0) begin
        // Stalled mid-frame: drop the partial frame once, then hold saturated.
        if (tcnt == T_LAST) begin
          bit_cnt  <= '0;
          rx_error <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_action_decoder.sv
// PS/2 keyboard to game action decoder: frame receiver plus prefix-tracking
// decode FSM. Optional parity check via `define PS2_PARITY_CHECK_EN.
module ps2_action_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] actions,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_error
);

  dec_state_t state, state_next;
  logic [1:0] act_next;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (scancode),
    .rx_valid(scancode_valid),
    .rx_error(frame_error)
  );

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_next = state;
    act_next   = '0;
    if (scancode_valid) begin
      case (state)
        ST_IDLE: begin
          if (scancode == SC_EXT)      state_next = ST_EXT;
          else if (scancode == SC_BRK) state_next = ST_BRK;
          else if (scancode == SC_D)   act_next[ACT_RIGHT] = 1'b1;
          else if (scancode == SC_A)   act_next[ACT_LEFT]  = 1'b1;
        end
        ST_EXT: begin
          state_next = ST_IDLE;
          if (scancode == SC_BRK)        state_next = ST_EXT_BRK;
          else if (scancode == SC_RIGHT) act_next[ACT_RIGHT] = 1'b1;
          else if (scancode == SC_LEFT)  act_next[ACT_LEFT]  = 1'b1;
        end
        default: state_next = ST_IDLE;  // break code: swallow the released key
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      actions <= '0;
    end else begin
      state   <= state_next;
      actions <= act_next;
    end
  end

endmodule

// File: doc/ps2_action_decoder.md
Name: ps2_action_decoder

Overview:
- Input-side producer of the game's `actions[1:0]` bus: receives PS/2 keyboard frames and decodes scancodes into one-cycle move pulses (bit0 = right, bit1 = left).
- Sits between the board PS/2 pins and the top-level game logic, clocked by the board `clock`.
- Also exports raw scancodes for debug/menu use.

Parameters:
- TIMEOUT_CYCLES, 4096, idle `clock` cycles mid-frame before the partial frame is discarded.
- SYNC_STAGES, 2, synchroniser depth on `ps2_clk`/`ps2_data` (min 2).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to `clock`.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to `clock`.
- actions  out  2  one-cycle pulses; [0] = right, [1] = left.
- scancode  out  8  last received data byte.
- scancode_valid  out  1  one-cycle pulse when `scancode` is updated.
- frame_error  out  1  one-cycle pulse on stop-bit, parity or timeout failure.

Behaviour:
- Reset/clock (already decided): one clock, `clock`; reset `reset_n` is asynchronous, active-low. Reset clears all outputs, synchronisers (to 1), the bit counter, the shift register, the timeout counter and the decode FSM.
- Input conditioning:
  - `ps2_clk` and `ps2_data` pass through SYNC_STAGES flops.
  - A falling edge is detected as previous synced `ps2_clk` = 1 and current = 0.
  - Data is sampled on the same cycle as the detected edge.
- Frame receiver: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
  - Bit counter 0..10; the shift register captures d0..d7.
  - Start bit sampled = 1: ignore the edge; the counter stays at 0.
  - After bit 10: the stop bit must be 1, else `frame_error` pulses and no byte is emitted.
  - On a good frame, `scancode` loads and `scancode_valid` pulses exactly 1 cycle after the 11th edge is detected.
- Timeout: the counter is reset on every falling edge and counts while the bit counter ≠ 0.
  - Reaching TIMEOUT_CYCLES-1 returns the bit counter to 0 and pulses `frame_error` once.
  - The counter saturates and never wraps.
- Decode FSM: states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). It advances only on `scancode_valid`.
  - IDLE: E0 → EXT; F0 → BRK; 0x23 ('D') → pulse `actions[0]`; 0x1C ('A') → pulse `actions[1]`; any other code → IDLE.
  - EXT: F0 → EXT_BRK; 0x74 (right arrow) → pulse `actions[0]`, IDLE; 0x6B (left arrow) → pulse `actions[1]`, IDLE; other → IDLE.
  - BRK and EXT_BRK: the next byte is consumed with no action, then IDLE.
- Action pulse timing and rules:
  - A pulse lasts exactly 1 cycle, registered 1 cycle after the `scancode_valid` of the deciding byte.
  - Both `actions` bits are never high together.
  - Keyboard typematic repeats (repeated make codes) yield repeated pulses; the block adds no autorepeat of its own.
- Errored frames do not advance the FSM.
- Reset asserted mid-frame or mid-prefix: all state is dropped and no pulse emits; the next valid frame decodes from IDLE.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: odd parity over d0..d7 plus the parity bit is checked. A mismatch pulses `frame_error` in the same cycle `scancode_valid` would have pulsed. No byte is emitted and the FSM does not advance.
- Undefined: the parity bit is sampled and ignored; only stop-bit and timeout errors exist.

Decomposition:
- Shared package `ps2_pkg`:
  - scancode constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_D=8'h23, SC_A=8'h1C, SC_RIGHT=8'h74, SC_LEFT=8'h6B.
  - decode-FSM state enum.
  - action bit indices ACT_RIGHT=0, ACT_LEFT=1.
- One sub-module `ps2_frame_rx`: synchroniser, edge detect, bit counter, timeout, parity/stop check. It outputs byte/valid/error.
- The top level holds the decode FSM and action registers.

Test Plan:
- Bench drives `ps2_clk` with a 40-cycle period, data changed at the half-period.
- Frame 0x23 with correct parity, stop=1 → `scancode`=8'h23, `scancode_valid` 1 cycle, `actions`=2'b01 for exactly 1 cycle one clock later.
- Sequence E0, 6B → `actions`=2'b10 pulse after the second byte only; sequence E0, F0, 6B → no action pulse, FSM back in IDLE.
- Sequence F0, 1C, then 1C → the first 1C is silent; the second gives `actions`=2'b10.
- Frame with stop bit = 0 → `frame_error` pulse, no `scancode_valid`, `scancode` unchanged. With PS2_PARITY_CHECK_EN, a parity-flipped 0x1C → `frame_error`, no action; without the macro → `actions`=2'b10.
- Stop `ps2_clk` after 5 bits for TIMEOUT_CYCLES → single `frame_error` pulse. A following clean 0x74 after E0 → `actions`=2'b01.
- Assert `reset_n`=0 after the E0 byte and 3 bits of the next frame, release, then send 0x74 → no action (IDLE treats 0x74 as unknown), and all outputs read 0 during reset.
